rggen_axi4lite_adapter_pipelined: RTL

AXI4-Lite slave front end that converts AW/W/AR traffic into single-beat register-bus requests, with decoupled per-channel response FIFOs. A new request can issue while earlier responses still await B/R acceptance. Selectable arbitration (write-first, read-first, round-robin) and a bus-ready timeout that forces SLVERR. Sits between the AXI4-Lite interconnect and the register-bus decode/adapter-common logic of a generated register block.

---
 rtl/rggen_axi4lite_adapter_pipelined.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rggen_axi4lite_adapter_pipelined.sv
// AXI4-Lite slave front end for a generated register block. AW/W and AR requests are
// turned into single-beat register-bus accesses, and B and R responses are queued in FIFOs.

module rggen_axi4lite_adapter_pipelined_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign w_pop   = i_pop && o_valid;
  // A pop in the same cycle frees the slot, so a push is accepted even when full.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module rggen_axi4lite_adapter_pipelined #(
  parameter int unsigned          ID_WIDTH          = 0,
  parameter int unsigned          ADDRESS_WIDTH     = 8,
  parameter int unsigned          BUS_WIDTH         = 32,
  parameter int unsigned          ARBITRATION       = 0,
  parameter int unsigned          RESPONSE_DEPTH    = 2,
  parameter int unsigned          TIMEOUT_CYCLES    = 0,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0
)(
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_awvalid,
  output logic                                      o_awready,
  input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_awid,
  input  logic [ADDRESS_WIDTH-1:0]                  i_awaddr,
  input  logic [2:0]                                i_awprot,
  input  logic                                      i_wvalid,
  output logic                                      o_wready,
  input  logic [BUS_WIDTH-1:0]                      i_wdata,
  input  logic [BUS_WIDTH/8-1:0]                    i_wstrb,
  output logic                                      o_bvalid,
  input  logic                                      i_bready,
  output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_bid,
  output logic [1:0]                                o_bresp,
  input  logic                                      i_arvalid,
  output logic                                      o_arready,
  input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_arid,
  input  logic [ADDRESS_WIDTH-1:0]                  i_araddr,
  input  logic [2:0]                                i_arprot,
  output logic                                      o_rvalid,
  input  logic                                      i_rready,
  output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_rid,
  output logic [1:0]                                o_rresp,
  output logic [BUS_WIDTH-1:0]                      o_rdata,
  output logic                                      o_bus_valid,
  output logic [1:0]                                o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]                  o_bus_address,
  output logic [BUS_WIDTH-1:0]                      o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]                    o_bus_strobe,
  input  logic                                      i_bus_ready,
  input  logic [1:0]                                i_bus_status,
  input  logic [BUS_WIDTH-1:0]                      i_bus_read_data,
  output logic                                      o_timeout
);
  localparam int unsigned IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam int unsigned BW  = IDW + 2;
  localparam int unsigned RW  = IDW + 2 + BUS_WIDTH;

  typedef enum logic [1:0] {
    LOCK_IDLE,
    LOCK_WRITE,
    LOCK_READ
  } lock_state_e;

  lock_state_e     r_state;
  lock_state_e     w_state_next;
  logic            r_last_read;
  logic [TW-1:0]   r_count;

  logic            w_b_full;
  logic            w_r_full;
  logic            w_write_ok;
  logic            w_read_ok;
  logic            w_grant_write;
  logic            w_timeout_hit;
  logic            w_complete;
  logic [1:0]      w_resp;
  logic [IDW-1:0]  w_awid;
  logic [IDW-1:0]  w_arid;
  logic [BW-1:0]   w_b_head;
  logic [RW-1:0]   w_r_head;
  logic            w_unused;

  assign w_unused   = ^{i_awprot, i_arprot};
  assign w_write_ok = i_awvalid && i_wvalid && !w_b_full;
  assign w_read_ok  = i_arvalid && !w_r_full;
  assign w_awid     = (ID_WIDTH == 0) ? '0 : i_awid;
  assign w_arid     = (ID_WIDTH == 0) ? '0 : i_arid;

  always_comb begin
    w_grant_write = 1'b0;
    case (r_state)
      LOCK_WRITE: w_grant_write = 1'b1;
      LOCK_READ:  w_grant_write = 1'b0;
      default: begin
        if (ARBITRATION == 1) begin
          w_grant_write = w_write_ok && !w_read_ok;
        end else if (ARBITRATION == 2) begin
          w_grant_write = w_write_ok && (!w_read_ok || r_last_read);
        end else begin
          w_grant_write = w_write_ok;
        end
      end
    endcase
  end

  assign o_bus_valid      = (r_state != LOCK_IDLE) || w_write_ok || w_read_ok;
  assign o_bus_access     = w_grant_write ? 2'b11 : 2'b10;
  assign o_bus_address    = w_grant_write ? i_awaddr : i_araddr;
  assign o_bus_write_data = i_wdata;
  assign o_bus_strobe     = i_wstrb;

  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && o_bus_valid && (r_count == TO_LAST);
  assign w_complete    = o_bus_valid && (i_bus_ready || w_timeout_hit);
  assign o_timeout     = w_timeout_hit && !i_bus_ready;
  assign w_resp        = i_bus_ready ? i_bus_status : 2'b10;

  assign o_awready = w_complete && w_grant_write;
  assign o_wready  = w_complete && w_grant_write;
  assign o_arready = w_complete && !w_grant_write;

  always_comb begin
    w_state_next = r_state;
    if (w_complete) begin
      w_state_next = LOCK_IDLE;
    end else if (o_bus_valid && (r_state == LOCK_IDLE)) begin
      w_state_next = w_grant_write ? LOCK_WRITE : LOCK_READ;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= LOCK_IDLE;
      r_last_read <= 1'b1;
      r_count     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_complete) begin
        r_last_read <= !w_grant_write;
        r_count     <= '0;
      end else if (o_bus_valid && !i_bus_ready) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  rggen_axi4lite_adapter_pipelined_fifo #(
    .WIDTH (BW),
    .DEPTH (RESPONSE_DEPTH)
  ) u_b_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (o_awready),
    .i_data  ({w_awid, w_resp}),
    .i_pop   (i_bready),
    .o_full  (w_b_full),
    .o_valid (o_bvalid),
    .o_data  (w_b_head)
  );

  rggen_axi4lite_adapter_pipelined_fifo #(
    .WIDTH (RW),
    .DEPTH (RESPONSE_DEPTH)
  ) u_r_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (o_arready),
    .i_data  ({w_arid, w_resp, (i_bus_ready ? i_bus_read_data : DEFAULT_READ_DATA)}),
    .i_pop   (i_rready),
    .o_full  (w_r_full),
    .o_valid (o_rvalid),
    .o_data  (w_r_head)
  );

  assign {o_bid, o_bresp}          = w_b_head;
  assign {o_rid, o_rresp, o_rdata} = w_r_head;
endmodule
